// File: rtl/elastic_pipeline_pkg.sv
// Shared types and helpers for the elastic pipeline: stage state encoding
// and the derivations of occupancy-counter width and total capacity.
package elastic_pipeline_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  // Wide enough to hold every count from 0 up to two entries per stage.
  function automatic int cntWidthFor(input int numStages);
    return $clog2(2 * numStages + 1);
  endfunction

  function automatic int capacityFor(input int numStages, input bit skidEn);
    return skidEn ? 2 * numStages : numStages;
  endfunction

endpackage

// File: rtl/elastic_stage.sv
// One elastic stage: a main register plus an optional skid register.
// Readiness is granted by the parent's ready chain; o_canAccept reports the local view.
module elastic_stage
  import elastic_pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SKID_EN    = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rstN,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_inValid,
  input  logic                  i_inReady,
  input  logic [DATA_WIDTH-1:0] i_inData,
  output logic                  o_canAccept,
  output logic                  o_outValid,
  input  logic                  i_outReady,
  output logic [DATA_WIDTH-1:0] o_outData,
  output logic [1:0]            o_occupancy
);

  logic                  r_mainValid;
  logic [DATA_WIDTH-1:0] r_mainData;
  logic                  w_hold;
  logic                  w_inXfer;
  logic                  w_outXfer;

  assign w_hold      = i_stall | i_flush;
  assign w_inXfer    = i_inValid & i_inReady & ~w_hold;
  assign w_outXfer   = r_mainValid & i_outReady & ~w_hold;
  assign o_outValid  = r_mainValid & ~w_hold;
  assign o_outData   = r_mainData;

  if (SKID_EN != 0) begin : gen_skid
    logic                  r_skidValid;
    logic [DATA_WIDTH-1:0] r_skidData;
    stage_state_e          w_state;

    always_comb begin
      w_state = EMPTY;
      if (r_skidValid)      w_state = FULL;
      else if (r_mainValid) w_state = BUSY;
    end

    // The skid register absorbs the one extra beat that arrives while the
    // registered ready is still high, so ready never depends on i_outReady.
    always_ff @(posedge i_clk or negedge i_rstN) begin
      if (!i_rstN) begin
        r_mainValid <= 1'b0;
        r_mainData  <= '0;
        r_skidValid <= 1'b0;
        r_skidData  <= '0;
      end else if (i_flush) begin
        r_mainValid <= 1'b0;
        r_skidValid <= 1'b0;
      end else begin
        case (w_state)
          EMPTY: begin
            if (w_inXfer) begin
              r_mainValid <= 1'b1;
              r_mainData  <= i_inData;
            end
          end
          BUSY: begin
            if (w_inXfer && !w_outXfer) begin
              r_skidValid <= 1'b1;
              r_skidData  <= i_inData;
            end else if (w_outXfer && !w_inXfer) begin
              r_mainValid <= 1'b0;
            end else if (w_inXfer && w_outXfer) begin
              r_mainData <= i_inData;
            end
          end
          FULL: begin
            if (w_outXfer) begin
              r_mainData  <= r_skidData;
              r_skidValid <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end

    assign o_canAccept = ~r_skidValid;
    assign o_occupancy = {1'b0, r_mainValid} + {1'b0, r_skidValid};
  end else begin : gen_plain
    always_ff @(posedge i_clk or negedge i_rstN) begin
      if (!i_rstN) begin
        r_mainValid <= 1'b0;
        r_mainData  <= '0;
      end else if (i_flush) begin
        r_mainValid <= 1'b0;
      end else if (w_inXfer) begin
        r_mainValid <= 1'b1;
        r_mainData  <= i_inData;
      end else if (w_outXfer) begin
        r_mainValid <= 1'b0;
      end
    end

    assign o_canAccept = ~r_mainValid;
    assign o_occupancy = {1'b0, r_mainValid};
  end

endmodule

// File: rtl/elastic_pipeline.sv
// Chain of NUM_STAGES elastic stages with shared stall/flush control,
// an occupancy counter and zero-gated output payload.
module elastic_pipeline
  import elastic_pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_STAGES = 2,
  parameter int SKID_EN    = 1,
  parameter int CNT_WIDTH  = cntWidthFor(NUM_STAGES)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  s_data_valid,
  output logic                  s_data_ready,
  input  logic [DATA_WIDTH-1:0] s_data_rdata,
  output logic                  m_data_valid,
  input  logic                  m_data_ready,
  output logic [DATA_WIDTH-1:0] m_data_rdata,
  input  logic                  s_ctrl_stall,
  input  logic                  s_ctrl_flush,
  output logic [CNT_WIDTH-1:0]  status_count
);

  localparam int CAPACITY = capacityFor(NUM_STAGES, SKID_EN != 0);

  if (NUM_STAGES < 1) begin : gen_badStages
    $error("elastic_pipeline: NUM_STAGES must be at least 1");
  end

  logic                  w_hold;
  logic [NUM_STAGES:0]   w_valid;
  logic [NUM_STAGES:0]   w_ready;
  logic [NUM_STAGES:0]   w_grant;
  logic [NUM_STAGES-1:0] w_canAccept;
  logic [DATA_WIDTH-1:0] w_data [NUM_STAGES+1];
  logic [1:0]            w_occ  [NUM_STAGES];
  logic [CNT_WIDTH-1:0]  w_count;

  assign w_hold     = s_ctrl_stall | s_ctrl_flush;
  assign w_valid[0] = s_data_valid;
  assign w_data[0]  = s_data_rdata;

  // Ready is resolved here in one place so that the plain-register mode can
  // ripple m_data_ready backwards without looping through the stage ports.
  always_comb begin
    w_ready             = '0;
    w_ready[NUM_STAGES] = m_data_ready;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      w_ready[i] = (SKID_EN != 0) ? w_canAccept[i] : (w_canAccept[i] | w_ready[i+1]);
    end
  end

  assign w_grant = w_ready & {(NUM_STAGES + 1){~w_hold}};

  for (genvar g = 0; g < NUM_STAGES; g++) begin : gen_stage
    elastic_stage #(
      .DATA_WIDTH(DATA_WIDTH),
      .SKID_EN   (SKID_EN)
    ) u_stage (
      .i_clk      (clk_i),
      .i_rstN     (rst_ni),
      .i_stall    (s_ctrl_stall),
      .i_flush    (s_ctrl_flush),
      .i_inValid  (w_valid[g]),
      .i_inReady  (w_grant[g]),
      .i_inData   (w_data[g]),
      .o_canAccept(w_canAccept[g]),
      .o_outValid (w_valid[g+1]),
      .i_outReady (w_grant[g+1]),
      .o_outData  (w_data[g+1]),
      .o_occupancy(w_occ[g])
    );
  end

  always_comb begin
    w_count = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      w_count = w_count + CNT_WIDTH'(w_occ[i]);
    end
  end

  assign s_data_ready = w_grant[0];
  assign m_data_valid = w_valid[NUM_STAGES] & ~w_hold;
  assign m_data_rdata = m_data_valid ? w_data[NUM_STAGES] : '0;
  assign status_count = w_count;

  capacityBound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    status_count <= CNT_WIDTH'(CAPACITY));

endmodule
